ltc2308_responder: RTL
======================

Name: ltc2308_responder

Overview:
- Synthesizable emulation of the LTC2308 ADC serial port: the responder end of the CONVST/SCK/SDI/SDO link driven by the FFT front-end's ADC interface.
- Lets the FFT path run on hardware or in simulation without the physical ADC.
- Samples come from an upstream source (pattern generator or ROM) through a request/valid handshake.
- Returns each 12-bit result MSB-first on SDO and captures the 6-bit config word from SDI for the next conversion.

Parameters:
- CONV_CYCLES, 8: clk cycles from the CONVST rising edge (post-synchronizer) to result-ready (tCONV).
- DATA_W, 12: result width in bits.
- CFG_W, 6: config word width in bits.

Ports:
- clk  in  1  system clock; must be at least 8x the SCK rate.
- reset_n  in  1  synchronous active-low reset.
- ADC_CONVST  in  1  conversion start from the initiator; asynchronous to clk.
- ADC_SCK  in  1  serial clock from the initiator; asynchronous to clk.
- ADC_SDI  in  1  config data, sampled on SCK rising edges.
- ADC_SDO  out  1  result data, MSB first.
- samp_req  out  1  one-cycle request for a new sample.
- samp_ch  out  3  channel for the current request, held stable from samp_req until the next request.
- samp_diff  out  1  1 = differential mode requested.
- samp_data  in  DATA_W  sample value from the upstream source.
- samp_valid  in  1  qualifies samp_data; only the first valid per request is used.
- cfg_word  out  CFG_W  active config word, bits {SD,OS,S1,S0,UNI,SLP}.
- frame_done  out  1  one-cycle pulse when a frame completes.
- late_err  out  1  one-cycle pulse when a sample arrives too late.

Behaviour:
- Reset values: ADC_SDO=0, samp_req=0, samp_ch=0, samp_diff=0, frame_done=0, late_err=0, cfg_word=6'b100010 (single-ended, CH0, unipolar, no sleep). Reset forces state IDLE and aborts any frame or conversion in progress.
- Input synchronization: CONVST, SCK and SDI each pass through a 2-flop synchronizer. Edges are detected against a third registered copy. Pin-to-action latency is 3 clk.
- Channel decode: samp_ch={S1,S0,OS} and samp_diff=~SD, both taken from cfg_word at request time.
- IDLE: SDO=0. On a CONVST rising edge:
  - latch samp_ch/samp_diff;
  - pulse samp_req;
  - load the conversion counter with CONV_CYCLES;
  - clear the captured flag;
  - go to CONVERT.
- CONVERT:
  - The counter decrements each clk.
  - The first samp_valid stores samp_data in the result register and sets the captured flag.
  - CONVST rising edges are ignored.
  - When the counter reaches 0: if captured is clear, result=0 and late_err pulses. Then go to READY.
  - samp_valid arriving in the same cycle the counter reaches 0 counts as in time.
- READY: when synchronized CONVST is low, drive SDO=result[DATA_W-1], set bit index=DATA_W-1, clear the SDI bit count, go to SHIFT. If CONVST is already low, this happens on the cycle READY is entered.
- SHIFT:
  - SCK rising edge: while the SDI bit count < CFG_W, shift SDI into the config shift register MSB-first and increment the count. Further rising edges are ignored.
  - SCK falling edge: decrement the index and drive SDO=result[index].
  - Falling edge when index=0: SDO=0, pulse frame_done, go to IDLE.
  - At frame end, if the SDI bit count == CFG_W, load cfg_word from the shift register one cycle later, in effect for the next conversion. Otherwise cfg_word is unchanged.
  - SCK edges seen outside SHIFT are ignored.
- CONVST rising edge during SHIFT or READY:
  - abort the frame (no frame_done);
  - commit the config only if all CFG_W bits were received;
  - start a new conversion exactly as from IDLE, in the same cycle, using the just-committed config.
- samp_valid outside CONVERT is ignored.

Test Plan:
- Nominal frame: reset; source returns 12'hA5C two cycles after samp_req; initiator shifts 12 SCK with SDI=6'b110010 -> SDO bits 1010_0101_1100; frame_done pulses once; cfg_word=6'b110010; next samp_ch=3'b001, samp_diff=0.
- Late sample: samp_valid asserted CONV_CYCLES+2 cycles after samp_req -> late_err pulses once; SDO shifts 12'h000; the late samp_data is ignored.
- Boundary valid: samp_valid with 12'hFFF in exactly the cycle the counter hits 0 -> no late_err; SDO shifts all ones.
- Partial config abort: 4 SCK cycles, then CONVST rises -> no frame_done; cfg_word stays 6'b100010; new samp_req with samp_ch=0.
- CONVST during CONVERT: second CONVST pulse 3 cycles after the first -> only one samp_req; the frame completes normally.
- Reset mid-SHIFT: reset_n low for 1 clk after 5 SCK cycles -> SDO=0, all pulses low, cfg_word=6'b100010; the next CONVST starts a clean frame.

Source files
------------

// File: rtl/ltc2308_responder.sv
// LTC2308 serial-port responder: emulates the ADC end of the CONVST/SCK/SDI/SDO link,
// sourcing conversion results from an upstream request/valid sample provider.
module ltc2308_responder #(
  parameter int CONV_CYCLES = 8,
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ADC_CONVST,
  input  logic              ADC_SCK,
  input  logic              ADC_SDI,
  output logic              ADC_SDO,
  output logic              samp_req,
  output logic [2:0]        samp_ch,
  output logic              samp_diff,
  input  logic [DATA_W-1:0] samp_data,
  input  logic              samp_valid,
  output logic [CFG_W-1:0]  cfg_word,
  output logic              frame_done,
  output logic              late_err
);

  localparam int CNT_W  = $clog2(CONV_CYCLES + 1);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SCNT_W = $clog2(CFG_W + 1);
  localparam int SD_B   = CFG_W - 1;
  localparam int OS_B   = CFG_W - 2;
  localparam int S1_B   = CFG_W - 3;
  localparam int S0_B   = CFG_W - 4;
  localparam logic [CFG_W-1:0] CFG_RESET = CFG_W'(6'b100010);

  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          convst_sync_q, sck_sync_q;
  logic [1:0]          sdi_sync_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                captured_q, captured_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SCNT_W-1:0]   sdi_cnt_q, sdi_cnt_d;
  logic [CFG_W-1:0]    cfg_sr_q, cfg_sr_d;
  logic [CFG_W-1:0]    cfg_word_q, cfg_word_d;
  logic                cfg_pend_q, cfg_pend_d;
  logic                sdo_q, sdo_d;
  logic                samp_req_q, samp_req_d;
  logic [2:0]          samp_ch_q, samp_ch_d;
  logic                samp_diff_q, samp_diff_d;
  logic                frame_done_q, frame_done_d;
  logic                late_err_q, late_err_d;
  logic                conv_rise, sck_rise, sck_fall;
  logic                start, commit, cfg_fresh;

  assign conv_rise = convst_sync_q[1] & ~convst_sync_q[2];
  assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    captured_d   = captured_q;
    result_d     = result_q;
    idx_d        = idx_q;
    sdi_cnt_d    = sdi_cnt_q;
    cfg_sr_d     = cfg_sr_q;
    cfg_word_d   = cfg_word_q;
    cfg_pend_d   = 1'b0;
    sdo_d        = sdo_q;
    samp_req_d   = 1'b0;
    samp_ch_d    = samp_ch_q;
    samp_diff_d  = samp_diff_q;
    frame_done_d = 1'b0;
    late_err_d   = 1'b0;
    start        = 1'b0;
    commit       = 1'b0;

    if (cfg_pend_q)
      cfg_word_d = cfg_sr_q;

    case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        if (conv_rise)
          start = 1'b1;
      end
      CONVERT: begin
        // A valid in the same cycle the counter sits at zero still counts as in time.
        if (cnt_q == '0) begin
          if (!captured_q) begin
            if (samp_valid) begin
              result_d = samp_data;
            end else begin
              result_d   = '0;
              late_err_d = 1'b1;
            end
          end
          state_d = READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (samp_valid && !captured_q) begin
            result_d   = samp_data;
            captured_d = 1'b1;
          end
        end
      end
      READY: begin
        if (conv_rise) begin
          start = 1'b1;
        end else if (!convst_sync_q[1]) begin
          sdo_d     = result_q[DATA_W-1];
          idx_d     = IDX_W'(DATA_W - 1);
          sdi_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (conv_rise) begin
          start  = 1'b1;
          commit = (sdi_cnt_q == SCNT_W'(CFG_W));
        end else begin
          if (sck_rise && (sdi_cnt_q < SCNT_W'(CFG_W))) begin
            cfg_sr_d  = {cfg_sr_q[CFG_W-2:0], sdi_sync_q[1]};
            sdi_cnt_d = sdi_cnt_q + SCNT_W'(1);
          end
          if (sck_fall) begin
            if (idx_q == '0) begin
              sdo_d        = 1'b0;
              frame_done_d = 1'b1;
              cfg_pend_d   = (sdi_cnt_q == SCNT_W'(CFG_W));
              state_d      = IDLE;
            end else begin
              idx_d = idx_q - IDX_W'(1);
              sdo_d = result_q[idx_q - IDX_W'(1)];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit)
      cfg_word_d = cfg_sr_q;

    // A config committed this cycle (or still pending) must steer the new request.
    cfg_fresh = commit | cfg_pend_q;
    if (start) begin
      samp_ch_d   = cfg_fresh ? {cfg_sr_q[S1_B], cfg_sr_q[S0_B], cfg_sr_q[OS_B]}
                              : {cfg_word_q[S1_B], cfg_word_q[S0_B], cfg_word_q[OS_B]};
      samp_diff_d = cfg_fresh ? ~cfg_sr_q[SD_B] : ~cfg_word_q[SD_B];
      samp_req_d  = 1'b1;
      cnt_d       = CNT_W'(CONV_CYCLES);
      captured_d  = 1'b0;
      sdi_cnt_d   = '0;
      sdo_d       = 1'b0;
      state_d     = CONVERT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      convst_sync_q <= '0;
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      captured_q    <= 1'b0;
      result_q      <= '0;
      idx_q         <= '0;
      sdi_cnt_q     <= '0;
      cfg_sr_q      <= '0;
      cfg_word_q    <= CFG_RESET;
      cfg_pend_q    <= 1'b0;
      sdo_q         <= 1'b0;
      samp_req_q    <= 1'b0;
      samp_ch_q     <= '0;
      samp_diff_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      late_err_q    <= 1'b0;
    end else begin
      convst_sync_q <= {convst_sync_q[1:0], ADC_CONVST};
      sck_sync_q    <= {sck_sync_q[1:0], ADC_SCK};
      sdi_sync_q    <= {sdi_sync_q[0], ADC_SDI};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      result_q      <= result_d;
      idx_q         <= idx_d;
      sdi_cnt_q     <= sdi_cnt_d;
      cfg_sr_q      <= cfg_sr_d;
      cfg_word_q    <= cfg_word_d;
      cfg_pend_q    <= cfg_pend_d;
      sdo_q         <= sdo_d;
      samp_req_q    <= samp_req_d;
      samp_ch_q     <= samp_ch_d;
      samp_diff_q   <= samp_diff_d;
      frame_done_q  <= frame_done_d;
      late_err_q    <= late_err_d;
    end
  end

  assign ADC_SDO    = sdo_q;
  assign samp_req   = samp_req_q;
  assign samp_ch    = samp_ch_q;
  assign samp_diff  = samp_diff_q;
  assign cfg_word   = cfg_word_q;
  assign frame_done = frame_done_q;
  assign late_err   = late_err_q;

endmodule
